// File: rtl/mips_decode_exec.sv
// Decode-and-execute slice of the single-cycle MIPS core: control decode, immediate
// extension, operand selection and ALU, with every output registered.
module mips_decode_exec #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  output logic [XLEN-1:0] alu_out,
  output logic            zero,
  output logic [XLEN-1:0] imm_ext,
  output logic [4:0]      alu_op,
  output logic [1:0]      reg_dst,
  output logic [1:0]      mem2reg,
  output logic            reg_wr,
  output logic            mem_wr
);

  localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_AND = 5'd2, ALU_OR = 5'd3,
                         ALU_XOR = 5'd4, ALU_NOR = 5'd5, ALU_SLT = 5'd6, ALU_SLTU = 5'd7,
                         ALU_SLL = 5'd8, ALU_SRL = 5'd9, ALU_SRA = 5'd10;

  logic [5:0]      op, funct;
  logic [4:0]      alu_op_c;
  logic [1:0]      reg_dst_c, mem2reg_c, src_a;
  logic            reg_wr_c, mem_wr_c, src_b, ext_sign;
  logic [XLEN-1:0] imm_c, opa, opb, res;
  logic [4:0]      sh;

  assign op    = instr[31:26];
  assign funct = instr[5:0];

  always_comb begin
    alu_op_c  = ALU_ADD;
    reg_dst_c = 2'd0;
    mem2reg_c = 2'd0;
    reg_wr_c  = 1'b0;
    mem_wr_c  = 1'b0;
    src_a     = 2'd0;
    src_b     = 1'b0;
    ext_sign  = 1'b1;
    case (op)
      6'h00: begin
        reg_dst_c = 2'd1;
        reg_wr_c  = 1'b1;
        case (funct)
          6'h20, 6'h21: alu_op_c = ALU_ADD;
          6'h22, 6'h23: alu_op_c = ALU_SUB;
          6'h24: alu_op_c = ALU_AND;
          6'h25: alu_op_c = ALU_OR;
          6'h26: alu_op_c = ALU_XOR;
          6'h27: alu_op_c = ALU_NOR;
          6'h2A: alu_op_c = ALU_SLT;
          6'h2B: alu_op_c = ALU_SLTU;
          6'h00: begin alu_op_c = ALU_SLL; src_a = 2'd2; end
          6'h02: begin alu_op_c = ALU_SRL; src_a = 2'd2; end
          6'h03: begin alu_op_c = ALU_SRA; src_a = 2'd2; end
          6'h04: alu_op_c = ALU_SLL;
          6'h06: alu_op_c = ALU_SRL;
          6'h07: alu_op_c = ALU_SRA;
          default: begin  // jr and unknown funct: no side effects
            reg_dst_c = 2'd0;
            reg_wr_c  = 1'b0;
          end
        endcase
      end
      6'h08, 6'h09: begin reg_wr_c = 1'b1; src_b = 1'b1; end
      6'h0A: begin alu_op_c = ALU_SLT;  reg_wr_c = 1'b1; src_b = 1'b1; end
      6'h0B: begin alu_op_c = ALU_SLTU; reg_wr_c = 1'b1; src_b = 1'b1; end
      6'h0C: begin alu_op_c = ALU_AND; reg_wr_c = 1'b1; src_b = 1'b1; ext_sign = 1'b0; end
      6'h0D: begin alu_op_c = ALU_OR;  reg_wr_c = 1'b1; src_b = 1'b1; ext_sign = 1'b0; end
      6'h0E: begin alu_op_c = ALU_XOR; reg_wr_c = 1'b1; src_b = 1'b1; ext_sign = 1'b0; end
      6'h0F: begin alu_op_c = ALU_SLL; reg_wr_c = 1'b1; src_a = 2'd1; src_b = 1'b1; end
      6'h23: begin mem2reg_c = 2'd1; reg_wr_c = 1'b1; src_b = 1'b1; end
      6'h2B: begin mem_wr_c = 1'b1; src_b = 1'b1; end
      6'h04, 6'h05: alu_op_c = ALU_SUB;
      6'h03: begin reg_dst_c = 2'd2; mem2reg_c = 2'd2; reg_wr_c = 1'b1; end
      default: ;
    endcase
    // sll r0,r0,0 decodes as an R-type write; the nop must not disturb r0 or memory
    if (instr == 32'h0) begin
      reg_wr_c = 1'b0;
      mem_wr_c = 1'b0;
    end
  end

  assign imm_c = ext_sign ? {{(XLEN-16){instr[15]}}, instr[15:0]}
                          : {{(XLEN-16){1'b0}}, instr[15:0]};

  always_comb begin
    case (src_a)
      2'd0:    opa = rs_data;
      2'd1:    opa = XLEN'(16);
      2'd2:    opa = {{(XLEN-5){1'b0}}, instr[10:6]};
      default: opa = '0;
    endcase
  end

  assign opb = src_b ? imm_c : rt_data;
  assign sh  = opa[4:0];

  always_comb begin
    case (alu_op_c)
      ALU_ADD:  res = opa + opb;
      ALU_SUB:  res = opa - opb;
      ALU_AND:  res = opa & opb;
      ALU_OR:   res = opa | opb;
      ALU_XOR:  res = opa ^ opb;
      ALU_NOR:  res = ~(opa | opb);
      ALU_SLT:  res = {{(XLEN-1){1'b0}}, ($signed(opa) < $signed(opb))};
      ALU_SLTU: res = {{(XLEN-1){1'b0}}, (opa < opb)};
      ALU_SLL:  res = opb << sh;
      ALU_SRL:  res = opb >> sh;
      ALU_SRA:  res = $signed(opb) >>> sh;
      default:  res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_out <= '0;
      zero    <= 1'b0;
      imm_ext <= '0;
      alu_op  <= '0;
      reg_dst <= '0;
      mem2reg <= '0;
      reg_wr  <= 1'b0;
      mem_wr  <= 1'b0;
    end else if (en) begin
      alu_out <= res;
      zero    <= (res == '0);
      imm_ext <= imm_c;
      alu_op  <= alu_op_c;
      reg_dst <= reg_dst_c;
      mem2reg <= mem2reg_c;
      reg_wr  <= reg_wr_c;
      mem_wr  <= mem_wr_c;
    end
  end

endmodule

// File: tb/tb_mips_decode_exec.sv
// Bench for mips_decode_exec: instruction vector table through a scoreboard queue,
// plus reset, enable-hold and nop sequences.
module tb_mips_decode_exec;

  typedef struct packed {
    logic [31:0] alu_out;
    logic        zero;
    logic [31:0] imm_ext;
    logic [4:0]  alu_op;
    logic [1:0]  reg_dst;
    logic [1:0]  mem2reg;
    logic        reg_wr;
    logic        mem_wr;
  } outs_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    outs_t       exp;
  } vec_t;

  logic        clk = 0, rst = 1, en = 0;
  logic [31:0] instr = '0, rs_data = '0, rt_data = '0;
  logic [31:0] alu_out, imm_ext;
  logic        zero, reg_wr, mem_wr;
  logic [4:0]  alu_op;
  logic [1:0]  reg_dst, mem2reg;

  int checks = 0, errors = 0;
  outs_t sb[$];
  vec_t  vecs[$];

  mips_decode_exec #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .en(en), .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .alu_out(alu_out), .zero(zero), .imm_ext(imm_ext), .alu_op(alu_op),
    .reg_dst(reg_dst), .mem2reg(mem2reg), .reg_wr(reg_wr), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input int rs, rt, rd, sh, fn);
    rtype = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, rs, rt, input logic [15:0] imm);
    itype = {6'(op), 5'(rs), 5'(rt), imm};
  endfunction

  function automatic vec_t mk(input string n, input logic [31:0] i, r, t, a,
                              input logic z, input logic [31:0] imm, input logic [4:0] op,
                              input logic [1:0] rd, m2r, input logic rw, mw);
    vec_t v;
    v.name = n; v.instr = i; v.rs = r; v.rt = t;
    v.exp = '{alu_out: a, zero: z, imm_ext: imm, alu_op: op, reg_dst: rd,
              mem2reg: m2r, reg_wr: rw, mem_wr: mw};
    return v;
  endfunction

  function automatic outs_t actual();
    return '{alu_out: alu_out, zero: zero, imm_ext: imm_ext, alu_op: alu_op,
             reg_dst: reg_dst, mem2reg: mem2reg, reg_wr: reg_wr, mem_wr: mem_wr};
  endfunction

  task automatic compare(input string n, input outs_t exp);
    outs_t act;
    act = actual();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got alu=%h z=%b imm=%h op=%0d dst=%0d m2r=%0d rw=%b mw=%b, want alu=%h z=%b imm=%h op=%0d dst=%0d m2r=%0d rw=%b mw=%b",
               n, act.alu_out, act.zero, act.imm_ext, act.alu_op, act.reg_dst, act.mem2reg,
               act.reg_wr, act.mem_wr, exp.alu_out, exp.zero, exp.imm_ext, exp.alu_op,
               exp.reg_dst, exp.mem2reg, exp.reg_wr, exp.mem_wr);
    end
  endtask

  task automatic check_pop(input string n);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got alu=%h want an entry", n, alu_out);
    end else begin
      compare(n, sb.pop_front());
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    instr = v.instr; rs_data = v.rs; rt_data = v.rt; en = 1;
    sb.push_back(v.exp);
    @(posedge clk);
    #1 check_pop(v.name);
  endtask

  initial begin
    outs_t zero_o, held;
    zero_o = '0;

    vecs.push_back(mk("add",    32'h00853020, 5, 7, 12, 0, 32'h00003020, 0, 1, 0, 1, 0));
    vecs.push_back(mk("sub_eq", rtype(1,2,3,0,'h22), 10, 10, 0, 1, 32'h00001822, 1, 1, 0, 1, 0));
    vecs.push_back(mk("and",    rtype(1,2,3,0,'h24), 32'hF0F0FFFF, 32'h0FF000FF, 32'h00F000FF, 0, 32'h00001824, 2, 1, 0, 1, 0));
    vecs.push_back(mk("nor",    rtype(1,2,3,0,'h27), 32'h0000FFFF, 32'h00FF0000, 32'hFF000000, 0, 32'h00001827, 5, 1, 0, 1, 0));
    vecs.push_back(mk("sltu",   rtype(1,2,3,0,'h2B), 1, 32'hFFFFFFFF, 1, 0, 32'h0000182B, 7, 1, 0, 1, 0));
    vecs.push_back(mk("slt",    rtype(1,2,3,0,'h2A), 32'hFFFFFFFF, 1, 1, 0, 32'h0000182A, 6, 1, 0, 1, 0));
    vecs.push_back(mk("sra4",   rtype(0,2,3,4,'h03), 32'h55, 32'h80000000, 32'hF8000000, 0, 32'h00001903, 10, 1, 0, 1, 0));
    vecs.push_back(mk("srlv",   rtype(1,2,3,0,'h06), 36, 32'h80000000, 32'h08000000, 0, 32'h00001806, 9, 1, 0, 1, 0));
    vecs.push_back(mk("sll31",  rtype(0,2,3,31,'h00), 0, 3, 32'h80000000, 0, 32'h00001FC0, 8, 1, 0, 1, 0));
    vecs.push_back(mk("lui",    itype('h0F,0,1,16'h1234), 32'h77, 32'h99, 32'h12340000, 0, 32'h00001234, 8, 0, 0, 1, 0));
    vecs.push_back(mk("andi",   itype('h0C,1,2,16'hFFFF), 32'hFFFFFFFF, 0, 32'h0000FFFF, 0, 32'h0000FFFF, 2, 0, 0, 1, 0));
    vecs.push_back(mk("slti",   itype('h0A,1,2,16'hFFFF), 32'hFFFFFFFE, 0, 1, 0, 32'hFFFFFFFF, 6, 0, 0, 1, 0));
    vecs.push_back(mk("sltiu",  itype('h0B,1,2,16'hFFFF), 5, 0, 1, 0, 32'hFFFFFFFF, 7, 0, 0, 1, 0));
    vecs.push_back(mk("addi_wrap", itype('h08,1,2,16'hFFFF), 1, 0, 0, 1, 32'hFFFFFFFF, 0, 0, 0, 1, 0));
    vecs.push_back(mk("xori",   itype('h0E,1,2,16'h8000), 32'hFFFF0000, 0, 32'hFFFF8000, 0, 32'h00008000, 4, 0, 0, 1, 0));
    vecs.push_back(mk("ori",    itype('h0D,1,2,16'h00F0), 32'h00000F00, 0, 32'h00000FF0, 0, 32'h000000F0, 3, 0, 0, 1, 0));
    vecs.push_back(mk("sw",     itype('h2B,1,2,16'h0008), 32'h100, 32'hDEAD, 32'h108, 0, 32'h8, 0, 0, 0, 0, 1));
    vecs.push_back(mk("lw",     itype('h23,1,2,16'h0008), 32'h100, 32'hDEAD, 32'h108, 0, 32'h8, 0, 0, 1, 1, 0));
    vecs.push_back(mk("beq",    itype('h04,1,2,16'h0010), 3, 3, 0, 1, 32'h10, 1, 0, 0, 0, 0));
    vecs.push_back(mk("bne",    itype('h05,1,2,16'hFFFC), 3, 4, 32'hFFFFFFFF, 0, 32'hFFFFFFFC, 1, 0, 0, 0, 0));
    vecs.push_back(mk("jal",    {6'h03, 26'h0000040}, 0, 0, 0, 1, 32'h40, 0, 2, 2, 1, 0));
    vecs.push_back(mk("j",      {6'h02, 26'h0000040}, 0, 0, 0, 1, 32'h40, 0, 0, 0, 0, 0));
    vecs.push_back(mk("jr",     rtype(1,0,0,0,'h08), 32'h400, 0, 32'h400, 0, 32'h8, 0, 0, 0, 0, 0));
    vecs.push_back(mk("bad_op", itype('h3F,1,2,16'h0000), 2, 0, 2, 0, 32'h0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("bad_fn", rtype(1,2,3,0,'h3F), 2, 0, 2, 0, 32'h0000183F, 0, 0, 0, 0, 0));

    // reset held across edges keeps everything at zero
    repeat (2) @(posedge clk);
    #1 compare("reset_hold", zero_o);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);

    // en=0 holds the last captured result for two edges
    drive(vecs[0]);
    held = vecs[0].exp;
    @(negedge clk);
    en = 0; instr = vecs[3].instr; rs_data = 32'h1234; rt_data = 32'h5678;
    sb.push_back(held);
    @(posedge clk);
    #1 check_pop("en0_hold1");
    sb.push_back(held);
    @(posedge clk);
    #1 check_pop("en0_hold2");

    // asynchronous reset mid-stream clears outputs between edges
    drive(vecs[9]);
    @(negedge clk);
    #2 rst = 1;
    #1 compare("async_reset", zero_o);
    en = 1;
    @(posedge clk);
    #1 compare("reset_over_edge", zero_o);
    @(negedge clk);
    rst = 0;
    drive(vecs[16]);

    // nop after a register-writing instruction must drop both write enables
    drive(vecs[0]);
    @(negedge clk);
    instr = 32'h0; rs_data = 32'h5; rt_data = 32'h7; en = 1;
    @(posedge clk);
    #1;
    checks++;
    if ({reg_wr, mem_wr} !== 2'b00) begin
      errors++;
      $display("FAIL nop_writes: got reg_wr=%b mem_wr=%b want 0 0", reg_wr, mem_wr);
    end

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_decode_exec.md
Name: mips_decode_exec

Overview:
- Decode-and-execute slice of the single-cycle MIPS core: instruction decoder (control), 16→32 immediate extender, operand selection and a 32-bit ALU.
- Consumes the fetched instruction and both register-file read values.
- Produces the register-write/memory controls, the extended immediate and the ALU result.
- All outputs are registered, so downstream logic sees them one clock after the instruction.

Parameters:
- XLEN, 32, datapath width (fixed at 32; no other value is supported).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  output register load enable; 0 holds all outputs.
- instr  in  32  current instruction.
- rs_data  in  32  register-file value addressed by instr[25:21].
- rt_data  in  32  register-file value addressed by instr[20:16].
- alu_out  out  32  ALU result.
- zero  out  1  high when the ALU result is 0.
- imm_ext  out  32  extended immediate.
- alu_op  out  5  ALU operation code.
- reg_dst  out  2  write-register select: 0 = rt, 1 = rd, 2 = r31.
- mem2reg  out  2  write-back select: 0 = ALU, 1 = memory, 2 = pc+4.
- reg_wr  out  1  register write enable.
- mem_wr  out  1  data memory write enable.

Behaviour:
- Reset: asynchronous, active-high. While rst=1 every output is 0. Reset asserted mid-operation clears outputs immediately, without waiting for a clock edge.
- Latency:
  - Combinational decode → ext → mux → ALU.
  - Results captured on the rising clk edge when en=1; hold when en=0.
  - Latency is exactly 1 cycle.
- Extender:
  - ext_sign=1: sign-extend instr[15:0].
  - ext_sign=0: zero-extend instr[15:0].
  - ext_sign=0 for andi, ori, xori; ext_sign=1 otherwise.
- ALU operand A select:
  - 0 = rs_data.
  - 1 = constant 16 (lui).
  - 2 = zero-extended shamt, instr[10:6].
  - 3 = 0.
- ALU operand B select: 0 = rt_data; 1 = imm_ext.
- ALU codes (B is the shifted operand; the shift amount is A[4:0]):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed, result 1/0), 7 SLTU (unsigned, result 1/0).
  - 8 SLL B<<A, 9 SRL B>>A, 10 SRA arithmetic B>>>A.
  - Codes 11–31 yield 0.
  - Add and subtract wrap modulo 2^32 with no overflow trap.
- Decode by R-type funct (op=0x00); these write rd (reg_dst=1, reg_wr=1):
  - add / addu (0x20 / 0x21) → ADD.
  - sub / subu (0x22 / 0x23) → SUB.
  - and 0x24, or 0x25, xor 0x26, nor 0x27 → AND, OR, XOR, NOR.
  - slt 0x2A → SLT; sltu 0x2B → SLTU.
  - sll 0x00, srl 0x02, sra 0x03 use srcA = 2 (shamt).
  - sllv 0x04, srlv 0x06, srav 0x07 use srcA = 0 (rs_data).
- jr (funct 0x08): reg_wr=0, mem_wr=0, alu_op=ADD.
- Decode by opcode:
  - I-type ALU ops (reg_dst=0, reg_wr=1, srcB=1):
    - addi / addiu (0x08 / 0x09) → ADD.
    - slti 0x0A → SLT; sltiu 0x0B → SLTU (immediate sign-extended, compare unsigned).
    - andi 0x0C, ori 0x0D, xori 0x0E → AND, OR, XOR (zero-extended immediate).
  - lui 0x0F → SLL with srcA = 1 and srcB = 1.
  - Memory:
    - lw 0x23: ADD base+imm, mem2reg=1, reg_wr=1.
    - sw 0x2B: ADD base+imm, mem_wr=1, reg_wr=0.
  - Branches beq 0x04 / bne 0x05: SUB rs−rt, no writes. The PC logic uses zero.
  - j 0x02: no writes.
  - jal 0x03: reg_dst=2, mem2reg=2, reg_wr=1.
- Special and unrecognised encodings:
  - instr == 0x00000000 (nop) forces reg_wr=0 and mem_wr=0.
  - Any unrecognised opcode or funct forces reg_wr=0 and mem_wr=0, with alu_op=ADD, reg_dst=0, mem2reg=0.
- zero is computed from the same-cycle ALU result and registered alongside it.

Test Plan:
- Reset: rst pulse asserted mid-stream → all outputs 0 without a clock edge. After release, the next edge with en=1 loads the new values.
- R-type add (0x00853020, rs=5, rt=7) → next cycle alu_out=12, reg_dst=1, reg_wr=1, mem_wr=0.
- Extender: lui 0x1234 → alu_out=0x12340000, reg_dst=0. andi imm 0xFFFF with rs=0xFFFFFFFF → imm_ext=0x0000FFFF, alu_out=0x0000FFFF.
- Signed vs unsigned compare: slti imm=0xFFFF (−1) with rs=0xFFFFFFFE → alu_out=1. sltu rs=1, rt=0xFFFFFFFF → alu_out=1.
- Memory ops: sw offset 8, base 0x100 → alu_out=0x108, mem_wr=1, reg_wr=0. lw with the same operands → mem2reg=1, reg_wr=1.
- Branch compare: beq with rs=rt=3 → zero=1. bne with rs=3, rt=4 → zero=0. sra shamt=4 on rt=0x80000000 → 0xF8000000. en=0 → outputs hold.
